// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encodings, index width and helpers shared by the reset sequencer.
package reset_seq_pkg;
    localparam logic [2:0] S_HOLD     = 3'd0;
    localparam logic [2:0] S_RELEASE  = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_FAULT    = 3'd5;
    localparam int IDX_W = 3;
    // One spare count: GAP compares against GAP_CYCLES itself.
    function automatic int cnt_width(input int h, input int g, input int a);
        int m;
        m = h > g ? h : g;
        m = m > a ? m : a;
        return $clog2(m + 1);
    endfunction
    function automatic logic [IDX_W-1:0] lowest_zero(input logic [7:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (!v[i]) r = IDX_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: 2-flop synchronizer with a one-cycle rising-edge pulse, async active-low clear.
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);
    logic r_s1, r_s2, r_s3;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {r_s1, r_s2, r_s3} <= '0;
        else        {r_s1, r_s2, r_s3} <= {i_d, r_s1, r_s2};
    assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all subsystems in reset until lock, then releases them one at a time
// on each stage's ready handshake; timeouts, ready loss and soft requests re-assert everything.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 10,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  locked,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  all_ready,
    output logic                  fault,
    output logic [2:0]            fault_stage
);
    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
    logic [2:0]            r_state, w_state;
    logic [IDX_W-1:0]      r_idx, w_idx, r_fs, w_fs;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [NUM_STAGES-1:0] r_rst, w_rst, w_clr;
    logic                  r_all, w_all, r_fault, w_fault, w_soft, w_last;
    logic [7:0]            w_rdy8, w_onehot;

    sync_rise_detect u_soft (
        .clk    (clk),
        .rst_n  (locked),
        .i_d    (soft_rst_req),
        .o_rise (w_soft)
    );

    // Unused upper bits read as ready so they never look like a dropped stage.
    always_comb begin
        w_rdy8 = '1;
        w_rdy8[NUM_STAGES-1:0] = stage_ready;
    end
    assign w_onehot = 8'd1 << r_idx;
    assign w_clr    = w_onehot[NUM_STAGES-1:0];
    assign w_last   = r_idx == IDX_W'(NUM_STAGES - 1);

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_rst   = r_rst;
        w_all   = r_all;
        w_fault = r_fault;
        w_fs    = r_fs;
        if (w_soft) begin
            w_state = S_HOLD;
            w_idx   = '0;
            w_rst   = '1;
            w_all   = 1'b0;
            w_fault = 1'b0;
        end else case (r_state)
            S_HOLD:
                if (r_cnt == CW'(HOLD_CYCLES - 1)) w_state = S_RELEASE;
            S_RELEASE: begin
                w_state = S_WAIT_ACK;
                w_rst   = r_rst & ~w_clr;
            end
            S_WAIT_ACK:
                if (w_rdy8[r_idx]) begin
                    w_state = w_last ? S_RUN : S_GAP;
                    w_all   = w_last;
                end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    w_state = S_FAULT;
                    w_fs    = r_idx;
                    w_rst   = '1;
                    w_fault = 1'b1;
                end
            S_GAP:
                if (r_cnt == CW'(GAP_CYCLES)) begin
                    w_state = S_RELEASE;
                    w_idx   = r_idx + 1'b1;
                end
            S_RUN:
                if (!(&w_rdy8)) begin
                    w_state = S_FAULT;
                    w_fs    = lowest_zero(w_rdy8);
                    w_rst   = '1;
                    w_all   = 1'b0;
                    w_fault = 1'b1;
                end
            default: ;
        endcase
        w_cnt = (w_soft || w_state != r_state) ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge locked)
        if (!locked) begin
            r_state <= S_HOLD;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rst   <= '1;
            r_all   <= 1'b0;
            r_fault <= 1'b0;
            r_fs    <= '0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_rst   <= w_rst;
            r_all   <= w_all;
            r_fault <= w_fault;
            r_fs    <= w_fs;
        end

    assign rst_out     = r_rst;
    assign all_ready   = r_all;
    assign fault       = r_fault;
    assign fault_stage = r_fs;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios with hand-computed edge timing for the reset sequencer.
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic [2:0] stage_ready = 3'b000;
    logic [2:0] rst_out;
    logic       all_ready;
    logic       fault;
    logic [2:0] fault_stage;
    int         errors = 0;
    int         checks = 0;

    reset_sequencer dut (
        .clk          (clk),
        .locked       (locked),
        .soft_rst_req (soft_rst_req),
        .stage_ready  (stage_ready),
        .rst_out      (rst_out),
        .all_ready    (all_ready),
        .fault        (fault),
        .fault_stage  (fault_stage)
    );

    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        edges(3);
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL reset_rst rst_out=%b expected=111", rst_out); end
        checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL reset_all_ready got=%b expected=0", all_ready); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b expected=0", fault); end
        checks++; if (fault_stage !== 3'd0) begin errors++; $display("FAIL reset_fault_stage got=%0d expected=0", fault_stage); end
    endtask

    // Edge 1 is the first rising edge after the sequence starts from HOLD with cnt=0.
    task automatic bring_up(input string tag);
        edges(10);
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL %s_e10 rst_out=%b expected=111", tag, rst_out); end
        edges(1);
        checks++; if (rst_out !== 3'b110) begin errors++; $display("FAIL %s_e11 rst_out=%b expected=110", tag, rst_out); end
        edges(3);
        stage_ready = 3'b001;
        edges(18);
        checks++; if (rst_out !== 3'b110) begin errors++; $display("FAIL %s_e32 rst_out=%b expected=110", tag, rst_out); end
        edges(1);
        checks++; if (rst_out !== 3'b100) begin errors++; $display("FAIL %s_e33 rst_out=%b expected=100", tag, rst_out); end
        edges(3);
        stage_ready = 3'b011;
        edges(18);
        checks++; if (rst_out !== 3'b100) begin errors++; $display("FAIL %s_e54 rst_out=%b expected=100", tag, rst_out); end
        edges(1);
        checks++; if (rst_out !== 3'b000) begin errors++; $display("FAIL %s_e55 rst_out=%b expected=000", tag, rst_out); end
        edges(3);
        checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL %s_e58 all_ready=%b expected=0", tag, all_ready); end
        stage_ready = 3'b111;
        edges(1);
        checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL %s_e59 all_ready=%b expected=1", tag, all_ready); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL %s_e59 fault=%b expected=0", tag, fault); end
    endtask

    task automatic test_nominal();
        @(negedge clk) locked = 1'b1;
        bring_up("nominal");
    endtask

    task automatic test_ready_loss();
        @(posedge clk) #1 stage_ready = 3'b010;
        checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL loss_pre all_ready=%b expected=1", all_ready); end
        edges(1);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL loss_fault got=%b expected=1", fault); end
        checks++; if (fault_stage !== 3'd0) begin errors++; $display("FAIL loss_stage got=%0d expected=0", fault_stage); end
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL loss_rst rst_out=%b expected=111", rst_out); end
        checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL loss_all_ready got=%b expected=0", all_ready); end
    endtask

    task automatic test_soft_mid();
        locked = 1'b0;
        stage_ready = 3'b000;
        @(negedge clk) locked = 1'b1;
        edges(11);
        checks++; if (rst_out !== 3'b110) begin errors++; $display("FAIL soft_e11 rst_out=%b expected=110", rst_out); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL soft_relock fault=%b expected=0", fault); end
        edges(3);
        stage_ready = 3'b001;
        edges(3);
        soft_rst_req = 1'b1;
        edges(2);
        checks++; if (rst_out !== 3'b110) begin errors++; $display("FAIL soft_edge2 rst_out=%b expected=110", rst_out); end
        edges(1);
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL soft_edge3 rst_out=%b expected=111", rst_out); end
        edges(10);
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL soft_hold10 rst_out=%b expected=111", rst_out); end
        edges(1);
        checks++; if (rst_out !== 3'b110) begin errors++; $display("FAIL soft_hold11 rst_out=%b expected=110", rst_out); end
        edges(18);
        checks++; if (rst_out !== 3'b110) begin errors++; $display("FAIL soft_held_gap rst_out=%b expected=110", rst_out); end
        edges(1);
        checks++; if (rst_out !== 3'b100) begin errors++; $display("FAIL soft_held_release rst_out=%b expected=100", rst_out); end
        soft_rst_req = 1'b0;
    endtask

    task automatic test_timeout();
        locked = 1'b0;
        stage_ready = 3'b000;
        @(negedge clk) locked = 1'b1;
        edges(14);
        stage_ready = 3'b001;
        edges(19);
        checks++; if (rst_out !== 3'b100) begin errors++; $display("FAIL to_enter rst_out=%b expected=100", rst_out); end
        edges(1023);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_early fault=%b expected=0", fault); end
        edges(1);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault got=%b expected=1", fault); end
        checks++; if (fault_stage !== 3'd1) begin errors++; $display("FAIL to_stage got=%0d expected=1", fault_stage); end
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL to_rst rst_out=%b expected=111", rst_out); end
        stage_ready = 3'b000;
        soft_rst_req = 1'b1;
        edges(2);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_soft_early fault=%b expected=1", fault); end
        edges(1);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_soft_clear fault=%b expected=0", fault); end
        checks++; if (fault_stage !== 3'd1) begin errors++; $display("FAIL to_soft_keep fault_stage=%0d expected=1", fault_stage); end
        bring_up("restart");
    endtask

    task automatic test_async_reset();
        checks++; if (fault_stage !== 3'd1) begin errors++; $display("FAIL async_pre fault_stage=%0d expected=1", fault_stage); end
        @(posedge clk) #3 locked = 1'b0;
        #1;
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL async_rst rst_out=%b expected=111", rst_out); end
        checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL async_all_ready got=%b expected=0", all_ready); end
        checks++; if (fault_stage !== 3'd0) begin errors++; $display("FAIL async_stage got=%0d expected=0", fault_stage); end
        soft_rst_req = 1'b0;
        stage_ready = 3'b000;
        @(negedge clk) locked = 1'b1;
        bring_up("relock");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ready_loss();
        test_soft_mid();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
